// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the pong renderers:
// pixel coordinates, active-low syncs, display enable and timing strobes.
interface vga_sync_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_tick;

  // Timing generator side
  modport master (
    output x,
    output y,
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output frame_tick
  );

  // Renderer side
  modport slave (
    input x,
    input y,
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz at the default parameters).
// A clock divider produces a one-clk pixel enable; horizontal and vertical
// counters advance on that enable. Every output is either a register or a
// decode of registers only, so renderers see stable values for a whole pixel.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int CNT_W   = 10;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);

  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  // Active-low sync decode: low for lo <= cnt < hi.
  function automatic logic sync_n(input logic [CNT_W-1:0] cnt,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return !((cnt >= lo) && (cnt < hi));
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hsync_q;
  logic             vsync_q;
  logic             p_tick;
  logic             h_last;
  logic             v_last;

  assign p_tick = (div_cnt == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (p_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Next raster position; vertical advances only when the line wraps.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (p_tick) begin
      if (h_last) begin
        h_nxt = '0;
        if (v_last) begin
          v_nxt = '0;
        end else begin
          v_nxt = v_cnt + CNT_W'(1);
        end
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end
    end
  end

  // Counter and sync registers; syncs load from the next position so they
  // switch on the same edge as the coordinates they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      hsync_q <= sync_n(h_nxt, HS_START, HS_END);
      vsync_q <= sync_n(v_nxt, VS_START, VS_END);
    end
  end

  assign vga.x          = h_cnt;
  assign vga.y          = v_cnt;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vga.p_tick     = p_tick;
  assign vga.frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing instance (line
// level) plus a small override instance for frame-level behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vga_a)
  );

  vga_sync_gen #(
    .CLK_DIV   (2),
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (2),
    .H_BACK    (2),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vga_b)
  );

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] pat;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (vga_a.x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", vga_a.x); end
    checks++; if (vga_a.y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", vga_a.y); end
    checks++; if (vga_a.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", vga_a.hsync); end
    checks++; if (vga_a.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vga_a.vsync); end
    checks++; if (vga_a.video_on !== 1'b1) begin errors++; $display("FAIL reset_video_on: got %b want 1", vga_a.video_on); end
    checks++; if (vga_a.p_tick !== 1'b0) begin errors++; $display("FAIL reset_p_tick: got %b want 0", vga_a.p_tick); end
    checks++; if (vga_a.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b want 0", vga_a.frame_tick); end
    checks++; if (vga_b.x !== 10'd0 || vga_b.hsync !== 1'b1) begin errors++; $display("FAIL reset_b: got x=%0d hsync=%b want 0/1", vga_b.x, vga_b.hsync); end
    // Release; p_tick must be high only during the 4th clock.
    rst_a = 1'b0;
    pat = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (vga_a.p_tick !== pat[i]) begin errors++; $display("FAIL first_p_tick[%0d]: got %b want %b", i, vga_a.p_tick, pat[i]); end
    end
    checks++; if (vga_a.x !== 10'd1) begin errors++; $display("FAIL first_x_step: got %0d want 1", vga_a.x); end
  endtask

  task automatic test_pixel_enable();
    int last_tick;
    logic [9:0] prev_x;
    logic prev_p;
    last_tick = -1;
    prev_x = vga_a.x;
    prev_p = vga_a.p_tick;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (!prev_p) begin
        if (vga_a.x !== prev_x) begin errors++; $display("FAIL x_hold: got %0d want %0d", vga_a.x, prev_x); end
      end else begin
        if (vga_a.x !== prev_x + 10'd1) begin errors++; $display("FAIL x_step: got %0d want %0d", vga_a.x, prev_x + 10'd1); end
      end
      if (vga_a.p_tick) begin
        if (last_tick >= 0) begin
          checks++;
          if (i - last_tick != 4) begin errors++; $display("FAIL p_tick_period: got %0d want 4", i - last_tick); end
        end
        last_tick = i;
      end
      prev_x = vga_a.x;
      prev_p = vga_a.p_tick;
    end
  endtask

  task automatic test_horizontal_sweep();
    int hs_fall, hs_rise, von_fall, hs_low, ft_cnt, vs_low, wrap1, wrap2;
    logic [9:0] prev_x, wrap_y;
    logic prev_hs, prev_von, wrap_von;
    hs_fall = -1; hs_rise = -1; von_fall = -1; wrap1 = -1; wrap2 = -1;
    hs_low = 0; ft_cnt = 0; vs_low = 0; wrap_y = '0; wrap_von = 1'b0;
    #2 rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    prev_x = vga_a.x; prev_hs = vga_a.hsync; prev_von = vga_a.video_on;
    for (int i = 1; i <= 6404; i++) begin
      step();
      if (prev_hs && !vga_a.hsync && hs_fall < 0) hs_fall = int'(vga_a.x);
      if (!prev_hs && vga_a.hsync && hs_rise < 0) hs_rise = int'(vga_a.x);
      if (prev_von && !vga_a.video_on && von_fall < 0) von_fall = int'(vga_a.x);
      if (vga_a.y == 10'd0 && !vga_a.hsync) hs_low++;
      if (vga_a.frame_tick) ft_cnt++;
      if (!vga_a.vsync) vs_low++;
      if (prev_x == 10'd799 && vga_a.x == 10'd0) begin
        if (wrap1 < 0) begin
          wrap1 = i; wrap_y = vga_a.y; wrap_von = vga_a.video_on;
        end else if (wrap2 < 0) begin
          wrap2 = i;
        end
      end
      prev_x = vga_a.x; prev_hs = vga_a.hsync; prev_von = vga_a.video_on;
    end
    checks++; if (hs_fall != 656) begin errors++; $display("FAIL hsync_fall_x: got %0d want 656", hs_fall); end
    checks++; if (hs_rise != 752) begin errors++; $display("FAIL hsync_rise_x: got %0d want 752", hs_rise); end
    checks++; if (von_fall != 640) begin errors++; $display("FAIL video_on_fall_x: got %0d want 640", von_fall); end
    checks++; if (hs_low != 384) begin errors++; $display("FAIL hsync_low_clks: got %0d want 384", hs_low); end
    checks++; if (wrap1 != 3200) begin errors++; $display("FAIL first_wrap_clk: got %0d want 3200", wrap1); end
    checks++; if (wrap2 - wrap1 != 3200) begin errors++; $display("FAIL line_period: got %0d want 3200", wrap2 - wrap1); end
    checks++; if (wrap_y !== 10'd1) begin errors++; $display("FAIL y_at_wrap: got %0d want 1", wrap_y); end
    checks++; if (wrap_von !== 1'b1) begin errors++; $display("FAIL video_on_rise_at_wrap: got %b want 1", wrap_von); end
    checks++; if (ft_cnt != 0) begin errors++; $display("FAIL frame_tick_in_line: got %0d want 0", ft_cnt); end
    checks++; if (vs_low != 0) begin errors++; $display("FAIL vsync_low_top_lines: got %0d want 0", vs_low); end
    checks++; if (vga_a.y !== 10'd2) begin errors++; $display("FAIL y_after_two_lines: got %0d want 2", vga_a.y); end
  endtask

  task automatic test_reset_mid_line();
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (vga_a.x == 10'd700) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL wait_x700: got timeout want x=700"); end
    checks++; if (vga_a.hsync !== 1'b0) begin errors++; $display("FAIL hsync_at_700: got %b want 0", vga_a.hsync); end
    #2 rst_a = 1'b1;
    #1;
    checks++; if (vga_a.x !== 10'd0 || vga_a.y !== 10'd0) begin errors++; $display("FAIL async_reset_xy: got %0d,%0d want 0,0", vga_a.x, vga_a.y); end
    checks++; if (vga_a.hsync !== 1'b1 || vga_a.vsync !== 1'b1) begin errors++; $display("FAIL async_reset_sync: got %b%b want 11", vga_a.hsync, vga_a.vsync); end
    checks++; if (vga_a.p_tick !== 1'b0) begin errors++; $display("FAIL async_reset_div: got p_tick=%b want 0", vga_a.p_tick); end
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    while (!vga_a.p_tick && n < 10) begin
      step();
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL p_tick_after_reset: got %0d edges want 3", n); end
  endtask

  task automatic test_override_frame();
    int ft_cnt, last_ft, wrap1, wrap2, max_y;
    logic [9:0] prev_x;
    logic prev_ft;
    logic exp_hs, exp_vs, exp_von;
    ft_cnt = 0; last_ft = -1; wrap1 = -1; wrap2 = -1; max_y = 0;
    rst_b = 1'b0;
    prev_x = vga_b.x; prev_ft = vga_b.frame_tick;
    for (int i = 1; i <= 600; i++) begin
      step();
      exp_hs  = !(vga_b.x == 10'd10 || vga_b.x == 10'd11);
      exp_vs  = !(vga_b.y == 10'd5);
      exp_von = (vga_b.x < 10'd8) && (vga_b.y < 10'd4);
      checks++; if (vga_b.hsync !== exp_hs) begin errors++; $display("FAIL ov_hsync: x=%0d got %b want %b", vga_b.x, vga_b.hsync, exp_hs); end
      checks++; if (vga_b.vsync !== exp_vs) begin errors++; $display("FAIL ov_vsync: y=%0d got %b want %b", vga_b.y, vga_b.vsync, exp_vs); end
      checks++; if (vga_b.video_on !== exp_von) begin errors++; $display("FAIL ov_video_on: x=%0d y=%0d got %b want %b", vga_b.x, vga_b.y, vga_b.video_on, exp_von); end
      if (int'(vga_b.y) > max_y) max_y = int'(vga_b.y);
      if (prev_ft) begin
        checks++;
        if (vga_b.x !== 10'd0 || vga_b.y !== 10'd0 || vga_b.frame_tick !== 1'b0) begin
          errors++; $display("FAIL ov_after_frame: got x=%0d y=%0d ft=%b want 0 0 0", vga_b.x, vga_b.y, vga_b.frame_tick);
        end
      end
      if (vga_b.frame_tick) begin
        ft_cnt++;
        checks++;
        if (vga_b.x !== 10'd13 || vga_b.y !== 10'd6 || vga_b.p_tick !== 1'b1) begin
          errors++; $display("FAIL ov_frame_tick_pos: got x=%0d y=%0d p=%b want 13 6 1", vga_b.x, vga_b.y, vga_b.p_tick);
        end
        if (last_ft >= 0) begin
          checks++;
          if (i - last_ft != 196) begin errors++; $display("FAIL ov_frame_period: got %0d want 196", i - last_ft); end
        end
        last_ft = i;
      end
      if (prev_x == 10'd13 && vga_b.x == 10'd0) begin
        if (wrap1 < 0) wrap1 = i;
        else if (wrap2 < 0) wrap2 = i;
      end
      prev_x = vga_b.x; prev_ft = vga_b.frame_tick;
    end
    checks++; if (wrap2 - wrap1 != 28) begin errors++; $display("FAIL ov_line_period: got %0d want 28", wrap2 - wrap1); end
    checks++; if (ft_cnt != 3) begin errors++; $display("FAIL ov_frame_count: got %0d want 3", ft_cnt); end
    checks++; if (max_y != 6) begin errors++; $display("FAIL ov_max_y: got %0d want 6", max_y); end
  endtask

  task automatic test_reset_mid_vsync();
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (vga_b.y == 10'd5) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL wait_y5: got timeout want y=5"); end
    checks++; if (vga_b.vsync !== 1'b0) begin errors++; $display("FAIL vsync_at_y5: got %b want 0", vga_b.vsync); end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (vga_b.vsync !== 1'b1) begin errors++; $display("FAIL async_reset_vsync: got %b want 1", vga_b.vsync); end
    checks++; if (vga_b.x !== 10'd0 || vga_b.y !== 10'd0) begin errors++; $display("FAIL async_reset_b_xy: got %0d,%0d want 0,0", vga_b.x, vga_b.y); end
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    while (!vga_b.p_tick && n < 10) begin
      step();
      n++;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL ov_p_tick_after_reset: got %0d edges want 1", n); end
  endtask

  initial begin
    test_reset();
    test_pixel_enable();
    test_horizontal_sweep();
    test_reset_mid_line();
    test_override_frame();
    test_reset_mid_vsync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator that produces the 640x480 @ 60 Hz raster for the pong display. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical counters. It drives the pixel coordinates `x`/`y` consumed by every glyph, paddle and ball renderer, along with the active-low sync pulses and a display-enable. All outputs are registered or decoded only from registered state, so renderers see a stable coordinate for a whole pixel period.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines

Ports:
- `clk`  in  1: system clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `x`  out  10: current horizontal count, 0..H_TOTAL-1.
- `y`  out  10: current vertical count, 0..V_TOTAL-1.
- `hsync`  out  1: active-low horizontal sync.
- `vsync`  out  1: active-low vertical sync.
- `video_on`  out  1: high when `x < H_DISPLAY` and `y < V_DISPLAY`.
- `p_tick`  out  1: one-`clk` pixel enable.
- `frame_tick`  out  1: one-`clk` pulse at the end of the frame.

## Operation
- Derived totals: H_TOTAL = sum of the four H_* parameters = 800. V_TOTAL = sum of the four V_* parameters = 525. Both counters are 10 bits wide, with no overflow at the defaults.
- Divider `div_cnt` counts 0..CLK_DIV-1, then wraps to 0. `p_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- Horizontal counter: on `clk` edges where `p_tick` = 1, `h_cnt` increments. When `h_cnt` == H_TOTAL-1 it instead wraps to 0.
- Vertical counter: `v_cnt` increments only on the `p_tick` edge where `h_cnt` wraps. When `v_cnt` == V_TOTAL-1 at that same edge, it wraps to 0.
- `x` = `h_cnt`; `y` = `v_cnt`. Both are held constant between `p_tick` edges, i.e. for CLK_DIV clocks.
- `hsync` = 0 iff H_DISPLAY+H_FRONT <= `h_cnt` < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
- `vsync` = 0 iff V_DISPLAY+V_FRONT <= `v_cnt` < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
- `hsync` and `vsync` are registers loaded from the next-state counter values, so they change on the same edge as `x`/`y`.
- `frame_tick` = `p_tick` AND (`h_cnt` == H_TOTAL-1) AND (`v_cnt` == V_TOTAL-1). It is high for exactly one `clk`, the cycle before both counters return to 0.
- There are no inputs other than clock and reset; the block free-runs.

## Timing
- Reset values: `div_cnt`=0, `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video_on`=1, `p_tick`=0, `frame_tick`=0.
- Reset assertion takes effect immediately, without waiting for a clock edge, including mid-line or mid-sync-pulse.
- After reset deassertion, the first `p_tick` is high during the CLK_DIV-th clock (clock 4). `x` becomes 1 on the edge that ends that clock.
- Counter update latency is 1 `clk` from `p_tick`. All outputs are glitch-free decodes of registers.
- Line period = H_TOTAL × CLK_DIV = 3200 `clk`. Frame period = 800 × 525 × 4 = 1,680,000 `clk`.
- `hsync` low width is 96 pixels = 384 `clk`. `vsync` low width is 2 lines = 6400 `clk`.
- Simultaneous wrap: at (799, 524) with `p_tick`, both counters return to 0 on the same edge. `vsync` returns to 1 on that edge if it is not already 1.
- `video_on` falls on the edge where `x` goes 639 -> 640 and rises on 799 -> 0 for lines with `y` < 480. It stays 0 for the whole of lines 480..524.

## Test plan
- Reset mid-frame: assert `reset` at `x`=700, `y`=300 between clock edges. Required: `x`, `y`, `div_cnt` = 0 and `hsync` = `vsync` = 1 immediately. After deassertion, the first `p_tick` occurs in the 4th clock.
- Pixel enable: count `clk` between consecutive `p_tick` pulses. Required: exactly 4 every time, each pulse 1 `clk` wide, and `x` stable between pulses.
- Horizontal sweep: run one full line. Required: `hsync` falls on the edge setting `x`=656 and rises on the edge setting `x`=752. `video_on` falls at `x`=640. `x` wraps from 799 to 0 and `y` increments on that same edge.
- Vertical sweep: run one frame. Required: `vsync` is low for `y`=490..491 only (6400 `clk`). `video_on` stays 0 for `y`=480..524. `y` wraps 524 -> 0.
- Frame boundary: at `x`=799, `y`=524 with `p_tick` high, `frame_tick` = 1 for exactly one `clk`. Required: the next state is `x`=0, `y`=0, and the count between `frame_tick` pulses is 1,680,000 `clk`.
- Parameter override: instantiate with CLK_DIV=2, H_DISPLAY=8, all H porches/sync=2, V_DISPLAY=4, all V porches/sync=1. Required: line period is 14 pixels (28 `clk`), frame period is 7 lines, `hsync` low at `x`=10..11, `vsync` low at `y`=5.
